// File: rtl/ddr_arb_pkg.sv
// Shared constants and types for the DDR3 Wishbone arbiter: bus widths,
// master-count limits and the FSM state encoding.
package ddr_arb_pkg;

  localparam int LINE_W      = 512;
  localparam int DM_W        = 64;
  localparam int ADDR_W      = 32;
  localparam int MAX_MASTERS = 4;
  localparam int IDX_W       = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_BUSY  = 2'b01,
    ARB_GAP   = 2'b10,
    ARB_DRAIN = 2'b11
  } arb_state_e;

endpackage

// File: rtl/ddr_ws_arbiter_rr_pick.sv
// Combinational winner picker: round-robin starting after the last served
// master, or fixed priority with master 0 highest.
module rr_pick
  import ddr_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic             round_robin,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [MAX_MASTERS-1:0] req_pad;
  logic [IDX_W-1:0]       idx;

  assign any = |req;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and no latch is inferred.
  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    winner         = '0;
    idx            = '0;
    if (round_robin) begin
      // Scan from the farthest candidate to the nearest; the last hit wins.
      for (int k = N; k >= 1; k--) begin
        idx = IDX_W'((int'(last) + k) % N);
        if (req_pad[idx]) winner = idx;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_pad[i]) winner = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ddr_ws_arbiter.sv
// Shares one 512-bit Wishbone slave port of the DDR3 wrapper between up to
// four masters, one transaction per grant, with a one-cycle gap after each ack.
module ddr_ws_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*LINE_W-1:0] m_din,
  input  logic [NUM_MASTERS*DM_W-1:0]   m_dm,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [LINE_W-1:0]             m_dout,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [LINE_W-1:0]             s_din,
  output logic [DM_W-1:0]               s_dm,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  input  logic                          s_ack,
  input  logic [LINE_W-1:0]             s_dout,
  output logic [1:0]                    dbg_state,
  output logic [1:0]                    dbg_grant,
  output logic                          dbg_abort
);

  // Per-master views padded to four entries so the 2-bit grant always
  // indexes a defined slot.
  logic [ADDR_W-1:0]      addr_a [MAX_MASTERS];
  logic [LINE_W-1:0]      din_a  [MAX_MASTERS];
  logic [DM_W-1:0]        dm_a   [MAX_MASTERS];
  logic [MAX_MASTERS-1:0] cyc_pad;
  logic [MAX_MASTERS-1:0] we_pad;

  for (genvar i = 0; i < MAX_MASTERS; i++) begin : g_pad
    if (i < NUM_MASTERS) begin : g_used
      assign addr_a[i]  = m_addr[i*ADDR_W +: ADDR_W];
      assign din_a[i]   = m_din[i*LINE_W +: LINE_W];
      assign dm_a[i]    = m_dm[i*DM_W +: DM_W];
      assign cyc_pad[i] = m_cyc[i];
      assign we_pad[i]  = m_we[i];
    end else begin : g_unused
      assign addr_a[i]  = '0;
      assign din_a[i]   = '0;
      assign dm_a[i]    = '0;
      assign cyc_pad[i] = 1'b0;
      assign we_pad[i]  = 1'b0;
    end
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             abort_q, abort_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             active;
  logic             ack_en;

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req         (m_cyc & m_stb),
    .last        (last_q),
    .round_robin (ROUND_ROBIN),
    .winner      (winner),
    .any         (any_req)
  );

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // asynchronous so outputs fall to idle the moment rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    abort_d = abort_q;
    active  = 1'b0;
    ack_en  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        active = 1'b1;
        if (s_ack) begin
          ack_en  = 1'b1;
          last_d  = grant_q;
          state_d = ARB_GAP;
        end else if (!cyc_pad[grant_q]) begin
          // The wrapper already holds the request; keep strobing until it acks.
          abort_d = 1'b1;
          state_d = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        active = 1'b1;
        if (s_ack) begin
          last_d  = grant_q;
          state_d = ARB_GAP;
        end
      end
      ARB_GAP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    m_ack = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_ack[i] = ack_en && (grant_q == IDX_W'(i));
    end
  end

  assign s_addr    = addr_a[grant_q];
  assign s_din     = din_a[grant_q];
  assign s_dm      = dm_a[grant_q];
  assign s_we      = active & we_pad[grant_q];
  assign s_cyc     = active;
  assign s_stb     = active;
  assign m_dout    = s_dout;
  assign dbg_state = state_q;
  assign dbg_grant = grant_q;
  assign dbg_abort = abort_q;

endmodule

// File: tb/tb_ddr_ws_arbiter.sv
// Bench for ddr_ws_arbiter: a three-master round-robin instance checked every
// cycle against a behavioural model, plus a two-master fixed-priority instance.
module tb_ddr_ws_arbiter;
  import ddr_arb_pkg::*;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*ADDR_W-1:0] m_addr = '0;
  logic [N*LINE_W-1:0] m_din  = '0;
  logic [N*DM_W-1:0]   m_dm   = '0;
  logic [N-1:0]        m_cyc  = '0, m_stb = '0, m_we = '0;
  logic [N-1:0]        m_ack;
  logic [LINE_W-1:0]   m_dout, s_din;
  logic [LINE_W-1:0]   s_dout = '0;
  logic [ADDR_W-1:0]   s_addr;
  logic [DM_W-1:0]     s_dm;
  logic                s_cyc, s_stb, s_we, s_ack;
  logic                slv_ack = 1'b0, stray_ack = 1'b0;
  logic [1:0]          dbg_state, dbg_grant;
  logic                dbg_abort;

  assign s_ack = slv_ack | stray_ack;

  ddr_ws_arbiter #(.NUM_MASTERS(N), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_din(m_din), .m_dm(m_dm),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_ack(m_ack), .m_dout(m_dout),
    .s_addr(s_addr), .s_din(s_din), .s_dm(s_dm), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_we(s_we), .s_ack(s_ack), .s_dout(s_dout), .dbg_state(dbg_state),
    .dbg_grant(dbg_grant), .dbg_abort(dbg_abort)
  );

  // Fixed-priority instance with its own masters and slave.
  logic [2*ADDR_W-1:0] fp_m_addr = '0;
  logic [2*LINE_W-1:0] fp_m_din  = '0;
  logic [2*DM_W-1:0]   fp_m_dm   = '0;
  logic [1:0]          fp_m_cyc  = '0, fp_m_stb = '0, fp_m_we = '0;
  logic [1:0]          fp_m_ack;
  logic [LINE_W-1:0]   fp_m_dout, fp_s_din;
  logic [LINE_W-1:0]   fp_s_dout = '0;
  logic [ADDR_W-1:0]   fp_s_addr;
  logic [DM_W-1:0]     fp_s_dm;
  logic                fp_s_cyc, fp_s_stb, fp_s_we;
  logic                fp_s_ack = 1'b0;
  logic [1:0]          fp_dbg_state, fp_dbg_grant;
  logic                fp_dbg_abort;

  ddr_ws_arbiter #(.NUM_MASTERS(2), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m_addr(fp_m_addr), .m_din(fp_m_din), .m_dm(fp_m_dm),
    .m_cyc(fp_m_cyc), .m_stb(fp_m_stb), .m_we(fp_m_we), .m_ack(fp_m_ack),
    .m_dout(fp_m_dout), .s_addr(fp_s_addr), .s_din(fp_s_din), .s_dm(fp_s_dm),
    .s_cyc(fp_s_cyc), .s_stb(fp_s_stb), .s_we(fp_s_we), .s_ack(fp_s_ack),
    .s_dout(fp_s_dout), .dbg_state(fp_dbg_state), .dbg_grant(fp_dbg_grant),
    .dbg_abort(fp_dbg_abort)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] pat(input int seed);
    logic [LINE_W-1:0] p;
    for (int w = 0; w < LINE_W / 32; w++) p[w*32 +: 32] = 32'hA5C3_0000 + 32'(seed * 256 + w);
    return p;
  endfunction

  // Slave: acks `lat` cycles after the strobe first appears, one-cycle pulse.
  int lat = 5;
  int cnt = 0;
  int slv_seq = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cnt = 0;
      slv_ack = 1'b0;
    end else if (slv_ack) begin
      slv_ack = 1'b0;
      cnt = 0;
    end else if (s_stb) begin
      cnt++;
      if (cnt == lat + 1) begin
        slv_ack = 1'b1;
        s_dout = pat(100 + slv_seq);
        slv_seq++;
      end
    end else begin
      cnt = 0;
    end
  end

  int fp_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      fp_cnt = 0;
      fp_s_ack = 1'b0;
    end else if (fp_s_ack) begin
      fp_s_ack = 1'b0;
      fp_cnt = 0;
    end else if (fp_s_stb) begin
      fp_cnt++;
      if (fp_cnt == 4) fp_s_ack = 1'b1;
    end else begin
      fp_cnt = 0;
    end
  end

  // Behavioural model: who owns the slave, whether that owner walked away,
  // and who was served last. phase 0 = free, 1 = owned, 2 = cooling down.
  int phase = 0, owner = 0, last_served = N - 1;
  bit walked_away = 1'b0, ever_aborted = 1'b0;

  function automatic int rr_next(input logic [N-1:0] req, input int after);
    for (int k = 1; k <= N; k++) if (req[(after + k) % N]) return (after + k) % N;
    return -1;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; owner = 0; last_served = N - 1; walked_away = 0; ever_aborted = 0;
    end else begin
      logic [N-1:0] exp_ack;
      logic [1:0]   exp_state;
      bit           owned;
      owned     = (phase == 1);
      exp_ack   = (owned && !walked_away && s_ack) ? N'(1 << owner) : '0;
      exp_state = owned ? (walked_away ? 2'd3 : 2'd1) : (phase == 2 ? 2'd2 : 2'd0);
      check("mdl_s_stb", s_stb, owned);
      check("mdl_s_cyc", s_cyc, owned);
      check("mdl_s_we", s_we, owned & m_we[owner]);
      check("mdl_m_ack", m_ack, exp_ack);
      check("mdl_state", dbg_state, exp_state);
      check("mdl_grant", dbg_grant, owner);
      check("mdl_abort", dbg_abort, ever_aborted);
      check("mdl_s_addr", s_addr, m_addr[owner*ADDR_W +: ADDR_W]);
      check("mdl_s_din", s_din, m_din[owner*LINE_W +: LINE_W]);
      check("mdl_s_dm", s_dm, m_dm[owner*DM_W +: DM_W]);
      check("mdl_m_dout", m_dout, s_dout);
      if (phase == 0) begin
        int w;
        w = rr_next(m_cyc & m_stb, last_served);
        if (w >= 0) begin
          owner = w; phase = 1; walked_away = 0;
        end
      end else if (phase == 1) begin
        if (s_ack) begin
          last_served = owner; phase = 2;
        end else if (!walked_away && !m_cyc[owner]) begin
          walked_away = 1; ever_aborted = 1;
        end
      end else begin
        phase = 0;
      end
    end
  end

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dbg_state == st) begin ok = 1'b1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_ack(input int i, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_ack[i]) begin ok = 1'b1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stb_cycles, n0, m1_early;
    bit ok;
    int order[$];

    m_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    m_din  = {pat(3), pat(2), pat(1)};
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, 2'b00);
    check("rst_stb", s_stb, 0);
    check("rst_grant", dbg_grant, 0);
    check("rst_abort", dbg_abort, 0);
    check("rst_mux_m0", s_addr, 32'h0000_1000);
    #2 rst_n = 1'b1;

    // Single read from m0 with a 20-cycle slave.
    drive_point();
    lat = 20;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    stb_cycles = 0; ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (s_stb) stb_cycles++;
      if (m_ack[0]) begin ok = 1'b1; break; end
    end
    check("read_ack_seen", ok, 1);
    check("read_stb_cycles", stb_cycles, 21);
    check("read_dout", m_dout, pat(100));
    drive_point();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    check("read_gap_stb", s_stb, 0);
    check("read_gap_state", dbg_state, 2'b10);
    @(negedge clk);
    check("read_idle_state", dbg_state, 2'b00);

    // Write pass-through from m1.
    drive_point();
    lat = 3;
    m_addr[ADDR_W +: ADDR_W] = 32'h0000_2040;
    m_din[LINE_W +: LINE_W]  = pat(7);
    m_dm[DM_W +: DM_W]       = 64'hFFFF_0000_0000_FFFF;
    m_we[1] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    wait_state(2'b01, 10, "wr_busy_seen");
    check("wr_addr", s_addr, 32'h0000_2040);
    check("wr_din", s_din, pat(7));
    check("wr_dm", s_dm, 64'hFFFF_0000_0000_FFFF);
    check("wr_we", s_we, 1);
    wait_ack(1, 20, "wr_ack_seen");
    check("wr_ack_only_m1", m_ack, 3'b010);
    drive_point();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    repeat (2) drive_point();

    // Round-robin contention between m0 and m1.
    lat = 5;
    m_addr[ADDR_W +: ADDR_W] = 32'h0000_3040;
    m_addr[0 +: ADDR_W]      = 32'h0000_3000;
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      @(negedge clk);
      if (m_ack != '0) order.push_back(m_ack[0] ? 0 : (m_ack[1] ? 1 : 2));
    end
    check("rr_ack_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) check($sformatf("rr_order_%0d", k), order[k], k % 2);
    drive_point();
    m_cyc[1:0] = 2'b00; m_stb[1:0] = 2'b00;
    repeat (2) drive_point();

    // Abort: m0 drops cyc mid-transaction while m1 waits.
    lat = 10;
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
    wait_state(2'b01, 10, "abort_busy_seen");
    check("abort_grant_m0", dbg_grant, 0);
    drive_point();
    drive_point();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s_ack) begin ok = 1'b1; break; end
    end
    check("abort_ack_seen", ok, 1);
    check("abort_no_m_ack", m_ack, 3'b000);
    check("abort_drain", dbg_state, 2'b11);
    @(negedge clk);
    check("abort_gap", dbg_state, 2'b10);
    check("abort_flag", dbg_abort, 1);
    @(negedge clk);
    check("abort_idle", dbg_state, 2'b00);
    @(negedge clk);
    check("abort_next_busy", dbg_state, 2'b01);
    check("abort_next_m1", dbg_grant, 1);
    wait_ack(1, 30, "abort_m1_ack");
    drive_point();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (2) drive_point();

    // Stray slave ack while idle.
    stray_ack = 1'b1;
    @(negedge clk);
    check("stray_no_ack", m_ack, 3'b000);
    drive_point();
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_still_idle", dbg_state, 2'b00);

    // Asynchronous reset while m1 is being served.
    drive_point();
    lat = 20;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    wait_state(2'b01, 10, "rstmid_busy_seen");
    check("rstmid_grant_m1", dbg_grant, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    check("rstmid_state", dbg_state, 2'b00);
    check("rstmid_stb", s_stb, 0);
    check("rstmid_cyc", s_cyc, 0);
    check("rstmid_we", s_we, 0);
    check("rstmid_ack", m_ack, 3'b000);
    check("rstmid_grant", dbg_grant, 0);
    check("rstmid_mux_m0", s_addr, m_addr[0 +: ADDR_W]);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_state(2'b01, 10, "rstmid_regrant");
    check("rstmid_first_m0", dbg_grant, 0);
    wait_ack(0, 40, "rstmid_m0_ack");
    drive_point();
    m_cyc = '0; m_stb = '0;
    repeat (3) drive_point();

    // Fixed priority: m1 waits until m0 stops re-requesting.
    fp_m_cyc = 2'b11; fp_m_stb = 2'b11;
    n0 = 0; m1_early = 0;
    for (int c = 0; c < 200 && n0 < 3; c++) begin
      @(negedge clk);
      if (fp_m_ack[1]) m1_early++;
      if (fp_m_ack[0]) n0++;
    end
    check("fp_m0_acks", n0, 3);
    check("fp_m1_starved", m1_early, 0);
    drive_point();
    fp_m_cyc[0] = 1'b0; fp_m_stb[0] = 1'b0;
    @(negedge clk);
    check("fp_gap", fp_dbg_state, 2'b10);
    @(negedge clk);
    check("fp_idle", fp_dbg_state, 2'b00);
    @(negedge clk);
    check("fp_busy", fp_dbg_state, 2'b01);
    check("fp_grant_m1", fp_dbg_grant, 1);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fp_m_ack[1]) begin ok = 1'b1; break; end
    end
    check("fp_m1_ack", ok, 1);
    drive_point();
    fp_m_cyc = '0; fp_m_stb = '0;
    repeat (2) drive_point();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
